reg_file: RTL and testbench

REG_FILE -- requirements
Module: reg_file

---
 rtl/reg_file_pkg.sv | 12 +
 rtl/reg_file_sign_extend.sv | 12 +
 rtl/reg_file.sv | 71 +++++++
 tb/tb_reg_file.sv | 133 +++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared sizing constants and types for the register file slice.
package reg_file_pkg;
  localparam int REG_COUNT = 32;
  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 5;
  localparam int IMM_W     = 16;

  localparam logic [DATA_W-1:0] MAGIC_VALUE = 32'hDEADBEEF;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ADDR_W-1:0] addr_t;
endpackage

// File: rtl/reg_file_sign_extend.sv
// Combinational sign extension of the immediate field to data width.
module sign_extend
  import reg_file_pkg::*;
(
  input  logic [IMM_W-1:0]  imm_in,
  output logic [DATA_W-1:0] imm_out
);

  // Replicate the immediate's sign bit into the upper bits.
  assign imm_out = {{(DATA_W-IMM_W){imm_in[IMM_W-1]}}, imm_in};

endmodule

// File: rtl/reg_file.sv
// 32x32 register file: two combinational read ports with write-through
// bypass, one write port, hardwired-zero r0, sticky magic-write flag and
// an immediate sign extender.
module reg_file
  import reg_file_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] read_addr_1,
  input  logic [ADDR_W-1:0] read_addr_2,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [DATA_W-1:0] write_data,
  input  logic              write_enabled,
  input  logic [IMM_W-1:0]  imm_in,
  output logic [DATA_W-1:0] data_1,
  output logic [DATA_W-1:0] data_2,
  output logic [DATA_W-1:0] imm_out,
  output logic              magic
);

  logic [REG_COUNT-1:0][DATA_W-1:0] regs_q, regs_d;
  logic                             magic_q, magic_d;
  logic                             wr_acc;

  // A write only counts when aimed at a real register; r0 writes vanish.
  // Reset is not folded in here so the bypass still shows during reset.
  assign wr_acc = write_enabled && (write_addr != '0);

  // Next-state: load the addressed register and latch the magic flag.
  always_comb begin
    regs_d  = regs_q;
    magic_d = magic_q;
    if (wr_acc) begin
      regs_d[write_addr] = write_data;
      if (write_data == MAGIC_VALUE) magic_d = 1'b1;
    end
  end

  // State register; reset wins over any simultaneous write.
  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q  <= '0;
      magic_q <= 1'b0;
    end else begin
      regs_q  <= regs_d;
      magic_q <= magic_d;
    end
  end

  // Read port 1: r0 reads zero, a same-cycle write to the address bypasses.
  always_comb begin
    data_1 = regs_q[read_addr_1];
    if (read_addr_1 == '0)                     data_1 = '0;
    else if (wr_acc && read_addr_1 == write_addr) data_1 = write_data;
  end

  // Read port 2: identical and independent of port 1.
  always_comb begin
    data_2 = regs_q[read_addr_2];
    if (read_addr_2 == '0)                     data_2 = '0;
    else if (wr_acc && read_addr_2 == write_addr) data_2 = write_data;
  end

  assign magic = magic_q;

  sign_extend u_sext (
    .imm_in  (imm_in),
    .imm_out (imm_out)
  );

endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file: the driver pushes expected outputs computed
// from an array model; a negedge monitor pops and compares.
module tb_reg_file;
  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  read_addr_1, read_addr_2, write_addr;
  logic [31:0] write_data;
  logic        write_enabled;
  logic [15:0] imm_in;
  logic [31:0] data_1, data_2, imm_out;
  logic        magic;

  reg_file dut (
    .clk(clk), .rst(rst),
    .read_addr_1(read_addr_1), .read_addr_2(read_addr_2),
    .write_addr(write_addr), .write_data(write_data),
    .write_enabled(write_enabled), .imm_in(imm_in),
    .data_1(data_1), .data_2(data_2), .imm_out(imm_out), .magic(magic)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] imm;
    logic        mg;
    string       tag;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] mem [32];
  logic        m_magic;
  bit          m_valid = 0;
  int          n_checks = 0;
  int          n_pass = 0;

  function automatic logic [31:0] m_read(input logic [4:0] ra);
    if (write_enabled && write_addr != 0 && ra == write_addr) return write_data;
    if (ra == 0) return 32'h0;
    return mem[ra];
  endfunction

  function automatic logic [31:0] m_sext(input logic [15:0] v);
    int s;
    s = (v >= 16'h8000) ? int'(v) - 65536 : int'(v);
    return 32'(s);
  endfunction

  // One cycle: commit the edge into the model, then drive and predict.
  task automatic cyc(input logic r, input logic [4:0] a1, input logic [4:0] a2,
                     input logic we, input logic [4:0] wa, input logic [31:0] wd,
                     input logic [15:0] im, input string tag);
    exp_t e;
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) mem[i] = 32'h0;
      m_magic = 1'b0;
      m_valid = 1;
    end else if (write_enabled && write_addr != 0) begin
      mem[write_addr] = write_data;
      if (write_data == 32'hDEADBEEF) m_magic = 1'b1;
    end
    #1;
    rst = r; read_addr_1 = a1; read_addr_2 = a2;
    write_enabled = we; write_addr = wa; write_data = wd; imm_in = im;
    if (m_valid) begin
      e.d1 = m_read(a1); e.d2 = m_read(a2);
      e.imm = m_sext(im); e.mg = m_magic; e.tag = tag;
      sbq.push_back(e);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: outputs are stable mid-cycle, compare against the queue head.
  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      chk({e.tag, ".data_1"}, data_1, e.d1);
      chk({e.tag, ".data_2"}, data_2, e.d2);
      chk({e.tag, ".imm_out"}, imm_out, e.imm);
      chk({e.tag, ".magic"}, {31'h0, magic}, {31'h0, e.mg});
    end
  end

  initial begin
    rst = 1; read_addr_1 = 0; read_addr_2 = 0; write_enabled = 0;
    write_addr = 0; write_data = 0; imm_in = 0;
    for (int i = 0; i < 32; i++) mem[i] = 32'hx;
    m_magic = 1'bx;
    // Reset held with a write to r7: write must be dropped.
    cyc(1, 7, 7, 1, 7, 32'hA5A5A5A5, 16'h0000, "rst_bypass");
    cyc(0, 7, 0, 0, 0, 0, 16'h0000, "rst_prio");
    for (int a = 1; a < 32; a++)
      cyc(0, 5'(a), 5'(32 - a), 0, 0, 0, 16'h1234, "rst_clear");
    // Write/read with same-cycle bypass then stored read.
    cyc(0, 5, 6, 1, 5, 32'h12345678, 16'h7FFF, "wr_bypass");
    cyc(0, 5, 5, 0, 0, 0, 16'h8000, "wr_read");
    cyc(0, 9, 9, 1, 9, 32'hCAFEF00D, 16'hFFFF, "both_bypass");
    // r0 protection.
    cyc(0, 0, 0, 1, 0, 32'hFFFFFFFF, 16'h0001, "r0_wr");
    cyc(0, 0, 5, 0, 0, 0, 16'h0000, "r0_after");
    // Magic set, sticky, cleared by reset.
    cyc(0, 3, 0, 1, 3, 32'hDEADBEEF, 16'h0, "magic_wr");
    cyc(0, 3, 0, 1, 3, 32'h0, 16'h0, "magic_set");
    cyc(0, 3, 0, 0, 0, 0, 16'h0, "magic_sticky");
    cyc(1, 3, 5, 0, 0, 0, 16'h0, "magic_rst");
    cyc(0, 3, 5, 0, 0, 0, 16'h0, "magic_clr");
    // Magic write to r0 is not accepted.
    cyc(0, 0, 0, 1, 0, 32'hDEADBEEF, 16'h0, "magic_r0");
    cyc(0, 0, 0, 0, 0, 0, 16'h0, "magic_r0_chk");
    // Random traffic with occasional mid-operation resets.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] wd;
      wd = ($urandom_range(0, 15) == 0) ? 32'hDEADBEEF : $urandom;
      cyc($urandom_range(0, 49) == 0, 5'($urandom), 5'($urandom),
          1'($urandom), 5'($urandom_range(0, 7)), wd, 16'($urandom), "rand");
    end
    cyc(0, 0, 0, 0, 0, 0, 16'h0, "tail");
    repeat (3) @(posedge clk);
    n_checks++;
    if (sbq.size() == 0) n_pass++;
    else $display("FAIL drain: %0d entries left, expected 0", sbq.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
